// File: rtl/uart_regbank.sv
// uart_regbank: serial-controlled bank of NUM_REGS byte registers (single and burst access).
// Define UART_REGBANK_ACK_EN to send an ack byte (0xA5 ok / 0xEE error) after write commands.

module uart_rx #(
    parameter int unsigned BIT_RATE = 9600,
    parameter int unsigned CLK_HZ   = 100000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       uart_rxd,
    output logic       uart_rx_break,
    output logic       uart_rx_valid,
    output logic [7:0] uart_rx_data
);
    localparam int unsigned Cpb = CLK_HZ / BIT_RATE;
    localparam int unsigned CW  = $clog2(Cpb + 1);

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;

    rx_state_e     state_q;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= RxIdle;
            sync_q        <= 2'b11;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            uart_rx_data  <= '0;
        end else begin
            sync_q        <= {sync_q[0], uart_rxd};
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            cnt_q         <= cnt_q + CW'(1);
            case (state_q)
                RxIdle: begin
                    cnt_q <= '0;
                    if (!sync_q[1]) state_q <= RxStart;
                end
                // Re-check the start bit at its midpoint to reject glitches.
                RxStart: if (cnt_q == CW'(Cpb / 2 - 1)) begin
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    state_q <= sync_q[1] ? RxIdle : RxData;
                end
                RxData: if (cnt_q == CW'(Cpb - 1)) begin
                    cnt_q   <= '0;
                    shift_q <= {sync_q[1], shift_q[7:1]};
                    bit_q   <= bit_q + 3'd1;
                    if (bit_q == 3'd7) state_q <= RxStop;
                end
                RxStop: if (cnt_q == CW'(Cpb - 1)) begin
                    cnt_q <= '0;
                    if (sync_q[1]) begin
                        uart_rx_valid <= 1'b1;
                        uart_rx_data  <= shift_q;
                        state_q       <= RxIdle;
                    end else begin
                        uart_rx_break <= (shift_q == 8'd0);
                        state_q       <= RxBreak;
                    end
                end
                RxBreak: if (sync_q[1]) state_q <= RxIdle;
                default: state_q <= RxIdle;
            endcase
        end
    end
endmodule

module uart_tx #(
    parameter int unsigned BIT_RATE = 9600,
    parameter int unsigned CLK_HZ   = 100000000
) (
    input  logic       clk,
    input  logic       resetn,
    output logic       uart_txd,
    output logic       uart_tx_busy,
    input  logic       uart_tx_en,
    input  logic [7:0] uart_tx_data
);
    localparam int unsigned Cpb = CLK_HZ / BIT_RATE;
    localparam int unsigned CW  = $clog2(Cpb + 1);

    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [8:0]    shift_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
        end else if (!uart_tx_busy) begin
            if (uart_tx_en) begin
                uart_tx_busy <= 1'b1;
                uart_txd     <= 1'b0;
                shift_q      <= {1'b1, uart_tx_data};
                cnt_q        <= '0;
                bit_q        <= '0;
            end
        end else if (cnt_q == CW'(Cpb - 1)) begin
            cnt_q <= '0;
            // bit_q counts bit periods already completed; 9 means the stop bit is done.
            if (bit_q == 4'd9) begin
                uart_tx_busy <= 1'b0;
            end else begin
                uart_txd <= shift_q[0];
                shift_q  <= {1'b1, shift_q[8:1]};
                bit_q    <= bit_q + 4'd1;
            end
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

module uart_regbank #(
    parameter int unsigned BIT_RATE       = 9600,
    parameter int unsigned CLK_HZ         = 100000000,
    parameter int unsigned NUM_REGS       = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rxd,
    output logic                  uart_txd,
    output logic [NUM_REGS*8-1:0] reg_out,
    output logic                  busy,
    output logic                  cmd_err
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        StIdle, StWrData, StBwCount, StBwData, StBrCount, StRdSend, StRdWait
`ifdef UART_REGBANK_ACK_EN
        , StAckSend, StAckWait
`endif
    } state_e;

    logic          resetn;
    logic          rx_valid, rx_break, tx_busy;
    logic [7:0]    rx_data;
    state_e        state_q, wr_done;
    logic [4:0]    addr_q, addr_inc;
    logic [7:0]    cnt_q, rd_byte;
    logic [TW-1:0] to_q;
    logic          seen_q, brk_q, tx_en_q, cmd_err_q;
    logic [7:0]    tx_data_q;
    logic [7:0]    regs_q [NUM_REGS];
    logic          addr_ok, to_run, to_abort, in_wait, wr_en, rd_fire, set_err;
`ifdef UART_REGBANK_ACK_EN
    logic          err_cmd_q;
`endif

    assign resetn  = ~reset;
    assign busy    = (state_q != StIdle);
    assign cmd_err = cmd_err_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign reg_out[8*k +: 8] = regs_q[k];
    end

    uart_rx #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ)) u_rx (
        .clk          (clk),
        .resetn       (resetn),
        .uart_rxd     (uart_rxd),
        .uart_rx_break(rx_break),
        .uart_rx_valid(rx_valid),
        .uart_rx_data (rx_data)
    );

    uart_tx #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ)) u_tx (
        .clk         (clk),
        .resetn      (resetn),
        .uart_txd    (uart_txd),
        .uart_tx_busy(tx_busy),
        .uart_tx_en  (tx_en_q),
        .uart_tx_data(tx_data_q)
    );

    always_comb begin
        addr_ok  = {1'b0, addr_q} < 6'(NUM_REGS);
        addr_inc = 5'((6'(addr_q) + 6'd1) % 6'(NUM_REGS));
        rd_byte  = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_q == 5'(k)) rd_byte = regs_q[k];
        end
        to_run   = (state_q == StWrData) || (state_q == StBwCount) ||
                   (state_q == StBwData) || (state_q == StBrCount);
        to_abort = to_run && (to_q == TW'(TIMEOUT_CYCLES)) && !rx_valid && !rx_break;
        wr_en    = rx_valid && ((state_q == StWrData) || (state_q == StBwData));
        rd_fire  = (state_q == StRdSend) && !tx_busy && !rx_break;
        set_err  = ((wr_en || rd_fire) && !addr_ok) || to_abort;
`ifdef UART_REGBANK_ACK_EN
        in_wait  = (state_q == StRdWait) || (state_q == StAckWait);
        wr_done  = StAckSend;
`else
        in_wait  = (state_q == StRdWait);
        wr_done  = StIdle;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            cnt_q     <= '0;
            to_q      <= '0;
            seen_q    <= 1'b0;
            brk_q     <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            cmd_err_q <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
`ifdef UART_REGBANK_ACK_EN
            err_cmd_q <= 1'b0;
`endif
        end else begin
            tx_en_q <= 1'b0;
            if (rx_valid || state_q == StIdle) to_q <= '0;
            else if (to_run) to_q <= to_q + TW'(1);
            if (wr_en) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (addr_q == 5'(k)) regs_q[k] <= rx_data;
                end
            end
            if (set_err) cmd_err_q <= 1'b1;
`ifdef UART_REGBANK_ACK_EN
            if (state_q == StIdle) err_cmd_q <= 1'b0;
            else if (set_err) err_cmd_q <= 1'b1;
`endif
            if (rx_break && !in_wait) begin
                state_q <= StIdle;
            end else if (to_abort) begin
                state_q <= (state_q == StBrCount) ? StIdle : wr_done;
            end else begin
                case (state_q)
                    StIdle: if (rx_valid) begin
                        addr_q <= rx_data[4:0];
                        case (rx_data[7:5])
                            3'b010: state_q <= StWrData;
                            3'b011: begin
                                cnt_q   <= 8'd1;
                                state_q <= StRdSend;
                            end
                            3'b100: state_q <= StBwCount;
                            3'b101: state_q <= StBrCount;
                            3'b111: cmd_err_q <= 1'b0;
                            default: cmd_err_q <= 1'b1;
                        endcase
                    end
                    StWrData: if (rx_valid) state_q <= wr_done;
                    StBwCount: if (rx_valid) begin
                        cnt_q   <= rx_data;
                        state_q <= (rx_data == 8'd0) ? StIdle : StBwData;
                    end
                    StBwData: if (rx_valid) begin
                        addr_q <= addr_inc;
                        cnt_q  <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) state_q <= wr_done;
                    end
                    StBrCount: if (rx_valid) begin
                        cnt_q   <= rx_data;
                        state_q <= (rx_data == 8'd0) ? StIdle : StRdSend;
                    end
                    StRdSend: if (rd_fire) begin
                        tx_en_q   <= 1'b1;
                        tx_data_q <= rd_byte;
                        seen_q    <= 1'b0;
                        brk_q     <= 1'b0;
                        state_q   <= StRdWait;
                    end
                    // A break here is remembered so the frame in flight completes first.
                    StRdWait: begin
                        if (rx_break) brk_q <= 1'b1;
                        if (tx_busy) begin
                            seen_q <= 1'b1;
                        end else if (seen_q) begin
                            cnt_q   <= cnt_q - 8'd1;
                            addr_q  <= addr_inc;
                            state_q <= (brk_q || rx_break || cnt_q == 8'd1) ? StIdle : StRdSend;
                        end
                    end
`ifdef UART_REGBANK_ACK_EN
                    StAckSend: if (!tx_busy) begin
                        tx_en_q   <= 1'b1;
                        tx_data_q <= err_cmd_q ? 8'hEE : 8'hA5;
                        seen_q    <= 1'b0;
                        state_q   <= StAckWait;
                    end
                    StAckWait: begin
                        if (tx_busy) seen_q <= 1'b1;
                        else if (seen_q) state_q <= StIdle;
                    end
`endif
                    default: state_q <= StIdle;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_regbank.sv
// Randomised scoreboard bench for uart_regbank: host-level register model plus serial tx monitor.

module tb_uart_regbank;
    localparam int unsigned NumRegs = 16;
    localparam int unsigned ClkHz   = 1000000;
    localparam int unsigned BitRate = 100000;
    localparam int unsigned Cpb     = ClkHz / BitRate;
    localparam int unsigned Timeout = 400;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 uart_rxd = 1'b1;
    logic                 uart_txd;
    logic [NumRegs*8-1:0] reg_out;
    logic                 busy;
    logic                 cmd_err;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] model_regs [NumRegs];
    logic       model_err;
    logic [7:0] exp_tx [$];
    logic [7:0] mon_byte;

    always #5 clk = ~clk;

    uart_regbank #(
        .BIT_RATE      (BitRate),
        .CLK_HZ        (ClkHz),
        .NUM_REGS      (NumRegs),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .uart_rxd(uart_rxd),
        .uart_txd(uart_txd),
        .reg_out (reg_out),
        .busy    (busy),
        .cmd_err (cmd_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic check_all();
        for (int k = 0; k < NumRegs; k++) begin
            check($sformatf("reg%0d", k), 32'(reg_out[8*k +: 8]), 32'(model_regs[k]));
        end
        check("cmd_err", 32'(cmd_err), 32'(model_err));
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = frame[i];
            repeat (Cpb) @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("busy_idle", 32'(busy), 32'd0);
        check("tx_drained", 32'(exp_tx.size()), 32'd0);
    endtask

    // Host-level operations: each sends its bytes and applies the command to the model.
    task automatic wr_single(input logic [4:0] a, input logic [7:0] d);
        int ai;
        ai = int'(a);
        send_byte({3'b010, a});
        send_byte(d);
        if (ai < NumRegs) model_regs[ai] = d;
        else model_err = 1'b1;
        wait_idle();
        check_all();
    endtask

    task automatic rd_single(input logic [4:0] a);
        int ai;
        ai = int'(a);
        if (ai < NumRegs) exp_tx.push_back(model_regs[ai]);
        else begin
            exp_tx.push_back(8'h00);
            model_err = 1'b1;
        end
        send_byte({3'b011, a});
        wait_idle();
        check_all();
    endtask

    task automatic burst_wr(input logic [4:0] a, input int n, input logic [31:0] data);
        send_byte({3'b100, a});
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            send_byte(data[8*i +: 8]);
            model_regs[(int'(a) + i) % NumRegs] = data[8*i +: 8];
        end
        wait_idle();
        check_all();
    endtask

    task automatic burst_rd(input logic [4:0] a, input int n);
        send_byte({3'b101, a});
        for (int i = 0; i < n; i++) exp_tx.push_back(model_regs[(int'(a) + i) % NumRegs]);
        send_byte(8'(n));
        wait_idle();
        check_all();
    endtask

    task automatic simple_cmd(input logic [7:0] b);
        send_byte(b);
        if (b[7:5] == 3'b111) model_err = 1'b0;
        else model_err = 1'b1;
        wait_idle();
        check_all();
    endtask

    // Serial monitor: decodes every frame on uart_txd and compares with the scoreboard.
    initial begin
        forever begin
            @(negedge uart_txd);
            repeat (Cpb / 2) @(negedge clk);
            check("tx_start", 32'(uart_txd), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (Cpb) @(negedge clk);
                mon_byte[i] = uart_txd;
            end
            repeat (Cpb) @(negedge clk);
            check("tx_stop", 32'(uart_txd), 32'd1);
            if (exp_tx.size() == 0) begin
                total_cnt++;
                $display("FAIL tx_unexpected: got byte 0x%0h, expected no tx byte", mon_byte);
            end else begin
                check("tx_byte", 32'(mon_byte), 32'(exp_tx.pop_front()));
            end
        end
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not complete, expected finish before 10ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int op;
        for (int k = 0; k < NumRegs; k++) model_regs[k] = 8'h00;
        model_err = 1'b0;
        repeat (3) @(negedge clk);
        check_all();
        check("busy_reset", 32'(busy), 32'd0);
        check("txd_reset", 32'(uart_txd), 32'd1);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Write then read back register 3.
        wr_single(5'd3, 8'h5A);
        rd_single(5'd3);
        // Burst write wrapping 14,15,0,1, then burst read 15,0,1.
        burst_wr(5'd14, 4, 32'h44332211);
        burst_rd(5'd15, 3);
        // Out-of-range write and read, then clear.
        wr_single(5'd20, 8'h99);
        rd_single(5'd20);
        simple_cmd(8'hE0);
        // Undefined command codes set the sticky error.
        simple_cmd(8'h20);
        simple_cmd(8'hE0);

        // Timeout: command byte with no data byte following.
        send_byte(8'h41);
        repeat (Timeout - 100) @(negedge clk);
        check("busy_pending", 32'(busy), 32'd1);
        repeat (150) @(negedge clk);
        check("busy_timeout", 32'(busy), 32'd0);
        model_err = 1'b1;
        check_all();
        simple_cmd(8'hE0);

        for (int t = 0; t < 30; t++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: wr_single(5'($urandom_range(0, 19)), 8'($urandom));
                1: rd_single(5'($urandom_range(0, 19)));
                2: burst_wr(5'($urandom_range(0, 15)), $urandom_range(0, 4), $urandom);
                3: burst_rd(5'($urandom_range(0, 15)), $urandom_range(0, 4));
                4: simple_cmd(8'hE0 | 8'($urandom_range(0, 31)));
                default: simple_cmd({3'($urandom_range(0, 1)), 5'($urandom_range(0, 31))});
            endcase
        end

        // Reset in the middle of a burst write.
        send_byte(8'h80);
        send_byte(8'h03);
        send_byte(8'h10);
        check("burst_reg0", 32'(reg_out[7:0]), 32'h10);
        check("busy_burst", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < NumRegs; k++) model_regs[k] = 8'h00;
        model_err = 1'b0;
        check("busy_after_reset", 32'(busy), 32'd0);
        check_all();
        repeat (5) @(negedge clk);
        wr_single(5'd5, 8'h77);
        rd_single(5'd5);

        repeat (20) @(negedge clk);
        check("tx_final_drained", 32'(exp_tx.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/uart_regbank.md
Name: uart_regbank

Overview:
- Parametrised UART-controlled register bank.
- A host on the serial line reads and writes NUM_REGS byte registers, one at a time or as an auto-incrementing burst.
- All registers are exported in parallel to the fabric.
- Instantiates the codebase uart_rx and uart_tx blocks; their resetn is driven by the inverse of reset.

Parameters:
- BIT_RATE, 9600, serial bit rate passed to uart_rx/uart_tx.
- CLK_HZ, 100000000, clk frequency in Hz passed to uart_rx/uart_tx.
- NUM_REGS, 16, number of 8-bit registers. Legal range 1..32.
- TIMEOUT_CYCLES, 1000000, clk cycles without a received byte before a pending command is aborted. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- uart_rxd  in  1  serial receive pin.
- uart_txd  out  1  serial transmit pin.
- reg_out  out  NUM_REGS*8  register contents; register k is at bits [8k+7:8k].
- busy  out  1  high whenever the FSM is not in IDLE.
- cmd_err  out  1  sticky error flag; cleared by reset or by the CLR command.

Behaviour:
- Reset values: all registers 0x00; reg_out 0; busy 0; cmd_err 0; FSM in IDLE; uart_txd idle high.
- Command byte format: cmd = byte[7:5], arg = byte[4:0], where arg is a register address.
- Commands: 010 write single, 011 read single, 100 burst write, 101 burst read, 111 clear cmd_err. Any other cmd is ignored and sets cmd_err.
- FSM states and transitions:
  - IDLE: on rx_valid, latch addr = arg and decode cmd.
  - WR_DATA: next rx byte is written to addr, then go to IDLE.
  - BW_COUNT: next rx byte is the count N. N = 0 goes to IDLE. Otherwise go to BW_DATA.
  - BW_DATA: each rx byte is written to addr; then addr increments and N decrements. When N reaches 0, go to IDLE.
  - BR_COUNT: next rx byte is N. N = 0 goes to IDLE. Otherwise go to RD_SEND.
  - RD_SEND: pulse tx_enable for exactly one cycle when tx_busy = 0, with tx_data = reg[addr]. Then go to RD_WAIT.
  - RD_WAIT: wait until tx_busy has been seen high and then low. Then decrement N (a single read uses N = 1) and increment addr. Return to RD_SEND if N != 0, otherwise go to IDLE.
- Address handling:
  - Auto-increment wraps modulo NUM_REGS.
  - For an address >= NUM_REGS: a write is dropped and sets cmd_err; a read transmits 0x00 and sets cmd_err.
  - Bursts continue normally past an out-of-range start address.
- Write visibility: a register write is visible on reg_out the cycle after the rx_valid that carries the data.
- Timeout:
  - The counter is cleared on every rx_valid and on entry to IDLE.
  - It counts only in WR_DATA, BW_COUNT, BW_DATA and BR_COUNT.
  - Reaching TIMEOUT_CYCLES goes to IDLE and sets cmd_err. Writes already done are kept.
- rx_break in any state: abort to IDLE at the next edge; in RD_WAIT, let the byte already being sent finish first. cmd_err is unchanged.
- Bytes received during RD_SEND/RD_WAIT are discarded; they are not queued.
- A reset asserted mid-operation returns everything to the reset values immediately. A partially sent byte on uart_txd is abandoned.
- Count and address arithmetic is 8-bit and 5-bit unsigned, with no saturation.

Optional Feature:
- Macro: UART_REGBANK_ACK_EN.
- When defined, a write-single or a completed burst write (N != 0) transmits an ack byte through ACK_SEND/ACK_WAIT states, using the same handshake as RD_SEND/RD_WAIT.
  - The ack is 0xA5 if no error occurred during that command, otherwise 0xEE.
  - A write aborted by timeout also sends 0xEE.
- When not defined, writes produce no tx traffic and the ACK states are not present.

Test Plan:
- Write then read back: send 0x43, 0x5A, then 0x63 -> reg_out[31:24] = 0x5A; uart_txd transmits 0x5A; busy returns to 0.
- Burst write with wrap (NUM_REGS=16): send 0x8E, 0x04, 0x11, 0x22, 0x33, 0x44 -> reg14 = 0x11, reg15 = 0x22, reg0 = 0x33, reg1 = 0x44; cmd_err stays 0.
- Burst read: after the previous test, send 0xAF, 0x03 -> tx bytes are 0x22, 0x33, 0x44, in order, with no overlap between frames.
- Out-of-range address (NUM_REGS=16): send 0x54, 0x99 -> no register changes and cmd_err = 1. Then send 0x74 -> tx 0x00. Then send 0xE0 -> cmd_err = 0.
- Timeout (TIMEOUT_CYCLES=50): send 0x41 and then idle -> 50 cycles later FSM is in IDLE, cmd_err = 1, reg1 unchanged. With ACK_EN defined, tx sends 0xEE.
- Reset mid-burst: send 0x80, 0x03, 0x10, then assert reset for 1 cycle -> all reg_out = 0, busy = 0. The next command is decoded normally.
